// File: rtl/pid_multichannel_core.sv
// Multi-channel fixed-point PID controller sharing a single multiplier.
// Each channel keeps its own coefficients, integrator and previous error.
// A sample moves through IDLE -> P -> I -> D -> SUM -> OUT, one cycle per
// state. OUT holds until the consumer accepts the result.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ena                         stall when low; all state is held
//   cfg_we/cfg_ch/cfg_sel/cfg_data
//                               coefficient write (sel 0=Kp 1=Ki 2=Kd,
//                               3=clear the integrator and e_prev)
//   e_valid/e_ready/e_ch/e      signed error sample input handshake
//   u_valid/u_ready/u_ch/u/u_sat
//                               saturated control output handshake
module pid_multichannel_core #(
  parameter  int unsigned DATA_W   = 6,
  parameter  int unsigned COEF_W   = 6,
  parameter  int unsigned FRAC_W   = 2,
  parameter  int unsigned INT_W    = 12,
  parameter  int unsigned CHANNELS = 2,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              e_valid,
  output logic              e_ready,
  input  logic [CH_W-1:0]   e_ch,
  input  logic [DATA_W-1:0] e,
  output logic              u_valid,
  input  logic              u_ready,
  output logic [CH_W-1:0]   u_ch,
  output logic [DATA_W-1:0] u,
  output logic              u_sat
);

  localparam int unsigned NCH    = 1 << CH_W;
  localparam int unsigned ACC_W  = INT_W + COEF_W + 3;
  localparam int unsigned PROD_W = INT_W + COEF_W + 1;
  localparam int unsigned DIF_W  = DATA_W + 1;

  localparam logic signed [INT_W:0]   IMAX = (INT_W+1)'((1 << (INT_W-1)) - 1);
  localparam logic signed [INT_W:0]   IMIN = (INT_W+1)'(-((1 << (INT_W-1)) - 1));
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] YMIN = ACC_W'(-(1 << (DATA_W-1)));

  // One bit per addressable channel number: set when the channel exists.
  function automatic logic [NCH-1:0] ch_mask_f();
    logic [NCH-1:0] m;
    for (int i = 0; i < NCH; i++) m[i] = (i < CHANNELS);
    return m;
  endfunction
  localparam logic [NCH-1:0] CH_MASK = ch_mask_f();

  typedef enum logic [2:0] {
    S_IDLE, S_P, S_I, S_D, S_SUM, S_OUT
  } state_e;

  state_e                    state_q;
  logic signed [DATA_W-1:0]  e_w_q;
  logic [CH_W-1:0]           ch_w_q;
  logic [COEF_W-1:0]         kp_w_q, ki_w_q, kd_w_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [INT_W-1:0]   inew_q;

  logic [COEF_W-1:0]         kp_q [NCH];
  logic [COEF_W-1:0]         ki_q [NCH];
  logic [COEF_W-1:0]         kd_q [NCH];
  logic signed [INT_W-1:0]   integ_q [NCH];
  logic signed [DATA_W-1:0]  eprev_q [NCH];

  logic                      u_valid_q, u_sat_q;
  logic [CH_W-1:0]           u_ch_q;
  logic [DATA_W-1:0]         u_q;

  logic signed [INT_W:0]     sum_i;
  logic signed [INT_W-1:0]   inew_d;
  logic signed [DIF_W-1:0]   diff;
  logic [COEF_W-1:0]         mul_coef;
  logic signed [INT_W-1:0]   mul_opnd;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   y;
  logic [DATA_W-1:0]         u_d;
  logic                      u_sat_d;
  logic                      windup;

  assign e_ready = ena && rst_n && (state_q == S_IDLE);
  assign u_valid = u_valid_q;
  assign u_ch    = u_ch_q;
  assign u       = u_q;
  assign u_sat   = u_sat_q;

  // Datapath: operand select for the shared multiplier, clamps and anti-windup.
  always_comb begin
    sum_i    = (INT_W+1)'(integ_q[ch_w_q]) + (INT_W+1)'(e_w_q);
    inew_d   = INT_W'(sum_i);
    if (sum_i > IMAX) inew_d = INT_W'(IMAX);
    if (sum_i < IMIN) inew_d = INT_W'(IMIN);

    diff     = DIF_W'(e_w_q) - DIF_W'(eprev_q[ch_w_q]);

    mul_coef = '0;
    mul_opnd = '0;
    case (state_q)
      S_P: begin mul_coef = kp_w_q; mul_opnd = INT_W'(e_w_q); end
      S_I: begin mul_coef = ki_w_q; mul_opnd = inew_d;        end
      S_D: begin mul_coef = kd_w_q; mul_opnd = INT_W'(diff);  end
      default: ;
    endcase
    // Coefficients are unsigned: a zero MSB keeps them non-negative.
    prod  = $signed({1'b0, mul_coef}) * mul_opnd;
    acc_d = ((state_q == S_P) ? '0 : acc_q) + ACC_W'(prod);

    y       = acc_q >>> FRAC_W;
    u_d     = DATA_W'(y);
    u_sat_d = 1'b0;
    if (y > YMAX) begin u_d = DATA_W'(YMAX); u_sat_d = 1'b1; end
    if (y < YMIN) begin u_d = DATA_W'(YMIN); u_sat_d = 1'b1; end

    // Integrator freezes while the output is saturated in the error's direction.
    windup = ((y > YMAX) && !e_w_q[DATA_W-1] && (e_w_q != '0)) ||
             ((y < YMIN) &&  e_w_q[DATA_W-1]);
  end

  // FSM, per-channel state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      e_w_q     <= '0;
      ch_w_q    <= '0;
      kp_w_q    <= '0;
      ki_w_q    <= '0;
      kd_w_q    <= '0;
      acc_q     <= '0;
      inew_q    <= '0;
      u_valid_q <= 1'b0;
      u_sat_q   <= 1'b0;
      u_ch_q    <= '0;
      u_q       <= '0;
      for (int i = 0; i < NCH; i++) begin
        kp_q[i]    <= '0;
        ki_q[i]    <= '0;
        kd_q[i]    <= '0;
        integ_q[i] <= '0;
        eprev_q[i] <= '0;
      end
    end else if (ena) begin
      if (cfg_we && CH_MASK[cfg_ch]) begin
        case (cfg_sel)
          2'd0: kp_q[cfg_ch] <= cfg_data;
          2'd1: ki_q[cfg_ch] <= cfg_data;
          2'd2: kd_q[cfg_ch] <= cfg_data;
          default: begin
            integ_q[cfg_ch] <= '0;
            eprev_q[cfg_ch] <= '0;
          end
        endcase
      end

      case (state_q)
        S_IDLE: begin
          // Samples for non-existent channels are consumed and dropped.
          if (e_valid && CH_MASK[e_ch]) begin
            e_w_q   <= e;
            ch_w_q  <= e_ch;
            kp_w_q  <= kp_q[e_ch];
            ki_w_q  <= ki_q[e_ch];
            kd_w_q  <= kd_q[e_ch];
            state_q <= S_P;
          end
        end
        S_P: begin
          acc_q   <= acc_d;
          state_q <= S_I;
        end
        S_I: begin
          acc_q   <= acc_d;
          inew_q  <= inew_d;
          state_q <= S_D;
        end
        S_D: begin
          acc_q   <= acc_d;
          state_q <= S_SUM;
        end
        S_SUM: begin
          // Placed after the cfg write so write-back wins over a same-cycle clear.
          u_q              <= u_d;
          u_sat_q          <= u_sat_d;
          u_ch_q           <= ch_w_q;
          u_valid_q        <= 1'b1;
          eprev_q[ch_w_q]  <= e_w_q;
          if (!windup) integ_q[ch_w_q] <= inew_q;
          state_q          <= S_OUT;
        end
        S_OUT: begin
          if (u_ready) begin
            u_valid_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_multichannel_core.sv
// Self-checking bench for pid_multichannel_core: directed scenarios plus
// randomized traffic, compared against an arithmetic model of the PID loop.
module tb_pid_multichannel_core;

  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_we, e_valid, e_ready, u_valid, u_ready, u_sat;
  logic [0:0] cfg_ch, e_ch, u_ch;
  logic [1:0] cfg_sel;
  logic [5:0] cfg_data, e, u;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int kp_m [2];
  int ki_m [2];
  int kd_m [2];
  int integ_m [2];
  int eprev_m [2];

  pid_multichannel_core dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .e_valid(e_valid), .e_ready(e_ready), .e_ch(e_ch), .e(e),
    .u_valid(u_valid), .u_ready(u_ready), .u_ch(u_ch), .u(u), .u_sat(u_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      kp_m[i] = 0; ki_m[i] = 0; kd_m[i] = 0; integ_m[i] = 0; eprev_m[i] = 0;
    end
  endtask

  // PID step: Kp*e + Ki*clamp(integ+e) + Kd*(e-e_prev), scaled by 1/4 with floor.
  task automatic model_step(input int ch, input int ev, output int eu, output int es);
    int inew, acc, y;
    inew = integ_m[ch] + ev;
    if (inew >  2047) inew =  2047;
    if (inew < -2047) inew = -2047;
    acc = kp_m[ch] * ev + ki_m[ch] * inew + kd_m[ch] * (ev - eprev_m[ch]);
    y   = (acc >= 0) ? acc / 4 : -((-acc + 3) / 4);
    eu  = (y > 31) ? 31 : (y < -32) ? -32 : y;
    es  = (eu != y) ? 1 : 0;
    eprev_m[ch] = ev;
    if (!((y > 31 && ev > 0) || (y < -32 && ev < 0))) integ_m[ch] = inew;
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_sel = 2'(sel); cfg_data = 6'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    case (sel)
      0: kp_m[ch] = data;
      1: ki_m[ch] = data;
      2: kd_m[ch] = data;
      default: begin integ_m[ch] = 0; eprev_m[ch] = 0; end
    endcase
  endtask

  // Send one sample, optionally stalling ena for `stall` cycles after accept,
  // then check latency and the result against the model.
  task automatic run_sample(input int ch, input int ev, input int stall, output int got_u);
    int eu, es, n;
    model_step(ch, ev, eu, es);
    n = 0;
    @(negedge clk);
    while (!e_ready && n < 50) begin @(negedge clk); n++; end
    chk("e_ready_wait", int'(e_ready), 1);
    e_valid = 1'b1; e_ch = 1'(ch); e = 6'(ev);
    @(negedge clk);
    e_valid = 1'b0;
    n = 0;
    while (!u_valid && n < 40) begin
      ena = (n >= stall);
      @(negedge clk);
      n++;
    end
    ena = 1'b1;
    // First rising edge at which u_valid is seen high, counted from the accept edge.
    chk("latency", n + 1, 5 + stall);
    got_u = int'($signed(u));
    chk("u", got_u, eu);
    chk("u_ch", int'(u_ch), ch);
    chk("u_sat", int'(u_sat), es);
    if (u_ready) begin
      @(negedge clk);
      chk("u_valid_drop", int'(u_valid), 0);
    end
  endtask

  initial begin
    int r;
    rst_n = 1'b1; ena = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    e_valid = 1'b0; e_ch = '0; e = '0; u_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_e_ready", int'(e_ready), 0);
    chk("rst_u_valid", int'(u_valid), 0);
    chk("rst_u", int'(u), 0);
    chk("rst_u_ch", int'(u_ch), 0);
    chk("rst_u_sat", int'(u_sat), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // P gain 2.0
    cfg_write(0, 0, 8);
    run_sample(0, 3, 0, r); chk("t1_p", r, 6);

    // Integral accumulation
    cfg_write(0, 0, 0); cfg_write(0, 1, 4); cfg_write(0, 3, 0);
    run_sample(0, 2, 0, r); chk("t2_i1", r, 2);
    run_sample(0, 2, 0, r); chk("t2_i2", r, 4);
    run_sample(0, 2, 0, r); chk("t2_i3", r, 6);

    // Derivative with an interleaved second channel
    cfg_write(0, 1, 0); cfg_write(0, 2, 4); cfg_write(0, 3, 0);
    cfg_write(1, 2, 4); cfg_write(1, 3, 0);
    run_sample(0, 3, 0, r);  chk("t3_d0a", r, 3);
    run_sample(1, -5, 0, r); chk("t3_d1", r, -5);
    run_sample(0, 7, 0, r);  chk("t3_d0b", r, 4);

    // Saturation and anti-windup
    cfg_write(0, 0, 63); cfg_write(0, 1, 4); cfg_write(0, 2, 0); cfg_write(0, 3, 0);
    run_sample(0, 10, 0, r); chk("t4_sat_u", r, 31); chk("t4_sat_flag", int'(u_sat), 1);
    cfg_write(0, 0, 0);
    run_sample(0, 0, 0, r); chk("t4_windup", r, 0);

    // ena stall mid-computation
    cfg_write(0, 1, 0); cfg_write(0, 0, 4);
    run_sample(0, 5, 3, r); chk("t_ena", r, 5);

    // Backpressure with a coefficient write during the stall
    cfg_write(0, 0, 8);
    u_ready = 1'b0;
    run_sample(0, 3, 0, r); chk("t5_u", r, 6);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) cfg_write(0, 0, 4);
      @(negedge clk);
      chk("t5_hold_valid", int'(u_valid), 1);
      chk("t5_hold_u", int'($signed(u)), 6);
      chk("t5_hold_ch", int'(u_ch), 0);
      chk("t5_hold_ready", int'(e_ready), 0);
    end
    u_ready = 1'b1;
    @(negedge clk);
    chk("t5_release", int'(u_valid), 0);
    run_sample(0, 3, 0, r); chk("t5_next", r, 3);

    // Reset while the sample is in the D state
    cfg_write(0, 1, 4);
    @(negedge clk);
    e_valid = 1'b1; e_ch = 1'b0; e = 6'd5;
    @(negedge clk);
    e_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(u_valid), 0);
    chk("t6_rst_ready", int'(e_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cfg_write(0, 0, 4);
    run_sample(0, 5, 0, r); chk("t6_after", r, 5);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int ch, ev, st;
      if ($urandom_range(2) == 0)
        cfg_write(int'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(63)));
      ch = int'($urandom_range(1));
      ev = int'($urandom_range(63)) - 32;
      st = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : 0;
      run_sample(ch, ev, st, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
